// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types for the register file and its neighbours.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = 4'd0;

endpackage

// File: rtl/regfile_2w2r_if.sv
// Bus bundle between decode/writeback and the register file.
interface regfile_2w2r_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              wr_en_a;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [DATA_W-1:0] wr_data_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] wr_addr_b;
  logic [DATA_W-1:0] wr_data_b;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [DATA_W-1:0] rd_data_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [DATA_W-1:0] rd_data_2;
  logic              busy_set_en;
  logic [ADDR_W-1:0] busy_set_addr;
  logic              busy_1;
  logic              busy_2;

  modport master (
    output wr_en_a, wr_addr_a, wr_data_a,
    output wr_en_b, wr_addr_b, wr_data_b,
    output rd_addr_1, rd_addr_2,
    output busy_set_en, busy_set_addr,
    input  rd_data_1, rd_data_2, busy_1, busy_2
  );

  modport slave (
    input  wr_en_a, wr_addr_a, wr_data_a,
    input  wr_en_b, wr_addr_b, wr_data_b,
    input  rd_addr_1, rd_addr_2,
    input  busy_set_en, busy_set_addr,
    output rd_data_1, rd_data_2, busy_1, busy_2
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: stored value, optional same-cycle write forwarding
// (port B over port A), and the registered busy flag of the addressed register.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter int DEPTH    = int'(32'd1 << ADDR_W)
) (
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic                         wr_en_a,
  input  logic [ADDR_W-1:0]            wr_addr_a,
  input  logic [DATA_W-1:0]            wr_data_a,
  input  logic                         wr_en_b,
  input  logic [ADDR_W-1:0]            wr_addr_b,
  input  logic [DATA_W-1:0]            wr_data_b,
  input  logic [DEPTH-1:0][DATA_W-1:0] regs,
  input  logic [DEPTH-1:0]             busy_vec,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         busy
);

  logic is_zero_s;

  assign is_zero_s = ZERO_REG && (rd_addr == ADDR_W'(ZERO_ADDR));

  // Read mux with forwarding; busy deliberately ignores a same-cycle clear
  always_comb begin
    rd_data = regs[rd_addr];
    busy    = busy_vec[rd_addr];
    if (BYPASS && !is_zero_s && wr_en_b && (wr_addr_b == rd_addr)) begin
      rd_data = wr_data_b;
    end else if (BYPASS && !is_zero_s && wr_en_a && (wr_addr_a == rd_addr)) begin
      rd_data = wr_data_a;
    end else begin
      rd_data = regs[rd_addr];
    end
  end

endmodule

// File: rtl/regfile_2w2r.sv
// Two-write/two-read register file with fixed B-over-A write priority, optional
// hardwired zero register and a per-register busy scoreboard.
module regfile_2w2r
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_2w2r_if.slave  bus
);

  localparam int DEPTH = int'(32'd1 << ADDR_W);

  logic [DEPTH-1:0][DATA_W-1:0] regs_r;
  logic [DEPTH-1:0][DATA_W-1:0] regs_next_s;
  logic [DEPTH-1:0]             busy_r;
  logic [DEPTH-1:0]             busy_next_s;
  logic                         we_a_s;
  logic                         we_b_s;

  // Writes to the hardwired zero register are dropped before they reach storage
  assign we_a_s = bus.wr_en_a && !(ZERO_REG && (bus.wr_addr_a == ADDR_W'(ZERO_ADDR)));
  assign we_b_s = bus.wr_en_b && !(ZERO_REG && (bus.wr_addr_b == ADDR_W'(ZERO_ADDR)));

  // Next storage and scoreboard state; busy set beats clear since a new producer issued
  always_comb begin
    regs_next_s = regs_r;
    busy_next_s = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (we_b_s && (bus.wr_addr_b == ADDR_W'(i))) begin
        regs_next_s[i] = bus.wr_data_b;
      end else if (we_a_s && (bus.wr_addr_a == ADDR_W'(i))) begin
        regs_next_s[i] = bus.wr_data_a;
      end else begin
        regs_next_s[i] = regs_r[i];
      end

      if (ZERO_REG && (ADDR_W'(i) == ADDR_W'(ZERO_ADDR))) begin
        busy_next_s[i] = 1'b0;
      end else if (bus.busy_set_en && (bus.busy_set_addr == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b1;
      end else if ((bus.wr_en_a && (bus.wr_addr_a == ADDR_W'(i))) ||
                   (bus.wr_en_b && (bus.wr_addr_b == ADDR_W'(i)))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
    end
  end

  // Storage and scoreboard registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_r <= {(DEPTH*DATA_W){1'b0}};
      busy_r <= {DEPTH{1'b0}};
    end else begin
      regs_r <= regs_next_s;
      busy_r <= busy_next_s;
    end
  end

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .DEPTH(DEPTH)
  ) u_rd_1 (
    .rd_addr   (bus.rd_addr_1),
    .wr_en_a   (bus.wr_en_a),
    .wr_addr_a (bus.wr_addr_a),
    .wr_data_a (bus.wr_data_a),
    .wr_en_b   (bus.wr_en_b),
    .wr_addr_b (bus.wr_addr_b),
    .wr_data_b (bus.wr_data_b),
    .regs      (regs_r),
    .busy_vec  (busy_r),
    .rd_data   (bus.rd_data_1),
    .busy      (bus.busy_1)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .DEPTH(DEPTH)
  ) u_rd_2 (
    .rd_addr   (bus.rd_addr_2),
    .wr_en_a   (bus.wr_en_a),
    .wr_addr_a (bus.wr_addr_a),
    .wr_data_a (bus.wr_data_a),
    .wr_en_b   (bus.wr_en_b),
    .wr_addr_b (bus.wr_addr_b),
    .wr_data_b (bus.wr_data_b),
    .regs      (regs_r),
    .busy_vec  (busy_r),
    .rd_data   (bus.rd_data_2),
    .busy      (bus.busy_2)
  );

endmodule
